// File: rtl/simt_scheduler.sv
// SIMT core scheduler: sequences FETCH..UPDATE for one block of threads,
// tracks a per-thread active mask and a divergence/reconvergence stack,
// and stretches EXECUTE for pipelined FMA instructions.

// Per-lane target comparator: does this lane's next PC match the primary
// target T, or the secondary (divergent) target P?
module simt_lane_match #(
  parameter int PCW = 8
) (
  input  logic [PCW-1:0] pc,
  input  logic [PCW-1:0] tgt,
  input  logic [PCW-1:0] alt,
  output logic           eq_tgt,
  output logic           eq_alt
);
  assign eq_tgt = (pc == tgt);
  assign eq_alt = (pc == alt);
endmodule

module simt_scheduler #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int STACK_DEPTH           = 4,
  parameter int FMA_LATENCY           = 2
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]                    thread_count,
  input  logic                                                  decoded_mem_read_enable,
  input  logic                                                  decoded_mem_write_enable,
  input  logic                                                  decoded_fma_enable,
  input  logic                                                  decoded_ret,
  input  logic [2:0]                                            fetcher_state,
  input  logic [THREADS_PER_BLOCK-1:0][1:0]                     lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                      current_pc,
  output logic [THREADS_PER_BLOCK-1:0]                          active_mask,
  output logic [2:0]                                            core_state,
  output logic [$clog2(STACK_DEPTH+1)-1:0]                      stack_ptr,
  output logic                                                  done,
  output logic [1:0]                                            error
);

  localparam int NT   = THREADS_PER_BLOCK;
  localparam int PCW  = PROGRAM_MEM_ADDR_BITS;
  localparam int SPW  = $clog2(STACK_DEPTH+1);
  localparam int CNTW = $clog2(FMA_LATENCY+1);

  localparam logic [SPW-1:0]  SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0]  SP_FULL = SPW'(STACK_DEPTH);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FMA = CNTW'(FMA_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  typedef struct packed {
    logic [NT-1:0]  mask;
    logic [PCW-1:0] pc;
  } stk_entry_t;

  state_t          state, state_n;
  logic [PCW-1:0]  pc_n;
  logic [NT-1:0]   mask_n;
  logic [SPW-1:0]  sp_n;
  logic            done_n;
  logic [1:0]      err_n;
  logic [CNTW-1:0] exec_cnt, cnt_n;
  logic            push;

  stk_entry_t      stk_mem [STACK_DEPTH];
  stk_entry_t      top;
  logic            stack_empty, stack_full;

  logic [NT-1:0]   launch_mask;
  logic            lsu_busy;
  logic [PCW-1:0]  tgt, alt;
  logic [NT-1:0]   eq_tgt, eq_alt;
  logic [NT-1:0]   grp_a, div_b;
  logic            multi_tgt;

  // Memory-op decode flags are informational only for this block.
  logic unused_mem_flags;
  assign unused_mem_flags = decoded_mem_read_enable ^ decoded_mem_write_enable;

  assign core_state  = state;
  assign stack_empty = (stack_ptr == '0);
  assign stack_full  = (stack_ptr == SP_FULL);

  // Launch mask: lowest min(thread_count, NT) bits set.
  always_comb begin
    launch_mask = '0;
    for (int i = 0; i < NT; i++) launch_mask[i] = (i < int'(thread_count));
  end

  // LSU stall: only active threads with an outstanding request hold WAIT.
  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < NT; i++)
      if (active_mask[i] && (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10))
        lsu_busy = 1'b1;
  end

  // Primary target T: next PC of the lowest active thread.
  always_comb begin
    tgt = '0;
    for (int i = NT-1; i >= 0; i--)
      if (active_mask[i]) tgt = next_pc[i];
  end

  // Per-lane comparisons against T and P.
  for (genvar g = 0; g < NT; g++) begin : g_lane
    simt_lane_match #(.PCW(PCW)) u_match (
      .pc     (next_pc[g]),
      .tgt    (tgt),
      .alt    (alt),
      .eq_tgt (eq_tgt[g]),
      .eq_alt (eq_alt[g])
    );
  end

  assign grp_a = active_mask & eq_tgt;
  assign div_b = active_mask & ~eq_tgt;

  // Secondary target P: next PC of the lowest diverging thread.
  always_comb begin
    alt = '0;
    for (int i = NT-1; i >= 0; i--)
      if (div_b[i]) alt = next_pc[i];
  end

  // A third distinct target is unsupported: B must agree on one PC.
  assign multi_tgt = |(div_b & ~eq_alt);

  // Top-of-stack read; loop compare keeps the index width-clean.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (i == int'(stack_ptr) - 1) top = stk_mem[i];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    pc_n    = current_pc;
    mask_n  = active_mask;
    sp_n    = stack_ptr;
    done_n  = done;
    err_n   = error;
    cnt_n   = exec_cnt;
    push    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (thread_count == '0) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            mask_n  = launch_mask;
            state_n = S_FETCH;
          end
        end
      end
      S_FETCH:   if (fetcher_state == 3'b010) state_n = S_DECODE;
      S_DECODE:  state_n = S_REQUEST;
      S_REQUEST: state_n = S_WAIT;
      S_WAIT: begin
        if (!lsu_busy) begin
          cnt_n   = decoded_fma_enable ? CNT_FMA : CNT_ONE;
          state_n = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (exec_cnt <= CNT_ONE) state_n = S_UPDATE;
        else                     cnt_n   = exec_cnt - CNT_ONE;
      end
      S_UPDATE: begin
        if (decoded_ret) begin
          if (stack_empty) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            mask_n  = top.mask;
            pc_n    = top.pc;
            sp_n    = stack_ptr - SP_ONE;
            state_n = S_FETCH;
          end
        end else if (div_b != '0) begin
          if (multi_tgt) begin
            err_n[1] = 1'b1;
            done_n   = 1'b1;
            state_n  = S_DONE;
          end else if (stack_full) begin
            err_n[0] = 1'b1;
            done_n   = 1'b1;
            state_n  = S_DONE;
          end else begin
            push    = 1'b1;
            sp_n    = stack_ptr + SP_ONE;
            mask_n  = grp_a;
            pc_n    = tgt;
            state_n = S_FETCH;
          end
        end else if (!stack_empty && tgt == top.pc) begin
          sp_n    = stack_ptr - SP_ONE;
          mask_n  = active_mask | top.mask;
          pc_n    = tgt;
          state_n = S_FETCH;
        end else begin
          pc_n    = tgt;
          state_n = S_FETCH;
        end
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      current_pc  <= '0;
      active_mask <= '0;
      stack_ptr   <= '0;
      done        <= 1'b0;
      error       <= '0;
      exec_cnt    <= '0;
    end else begin
      state       <= state_n;
      current_pc  <= pc_n;
      active_mask <= mask_n;
      stack_ptr   <= sp_n;
      done        <= done_n;
      error       <= err_n;
      exec_cnt    <= cnt_n;
    end
  end

  // Stack storage; contents need no reset since stack_ptr gates validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (push && i == int'(stack_ptr)) stk_mem[i] <= '{mask: div_b, pc: alt};
  end

endmodule

// File: tb/tb_simt_scheduler.sv
// Directed bench for simt_scheduler. Instance a: FMA_LATENCY=3, depth 4.
// Instance b: depth 1, shares all inputs, used for the overflow case.
module tb_simt_scheduler;
  localparam int T   = 4;
  localparam int PCW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] thread_count = '0;
  logic mem_rd = 1'b0, mem_wr = 1'b0, fma = 1'b0, ret = 1'b0;
  logic [2:0] fetcher_state = '0;
  logic [T-1:0][1:0] lsu_state = '0;
  logic [T-1:0][PCW-1:0] next_pc = '0;

  logic [PCW-1:0] pc_a, pc_b;
  logic [T-1:0]   mask_a, mask_b;
  logic [2:0]     cs_a, cs_b;
  logic [2:0]     sp_a;
  logic [0:0]     sp_b;
  logic           done_a, done_b;
  logic [1:0]     err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  simt_scheduler #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(PCW),
                   .STACK_DEPTH(4), .FMA_LATENCY(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .decoded_mem_read_enable(mem_rd), .decoded_mem_write_enable(mem_wr),
    .decoded_fma_enable(fma), .decoded_ret(ret), .fetcher_state(fetcher_state),
    .lsu_state(lsu_state), .next_pc(next_pc), .current_pc(pc_a),
    .active_mask(mask_a), .core_state(cs_a), .stack_ptr(sp_a),
    .done(done_a), .error(err_a));

  simt_scheduler #(.THREADS_PER_BLOCK(T), .PROGRAM_MEM_ADDR_BITS(PCW),
                   .STACK_DEPTH(1), .FMA_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .decoded_mem_read_enable(mem_rd), .decoded_mem_write_enable(mem_wr),
    .decoded_fma_enable(fma), .decoded_ret(ret), .fetcher_state(fetcher_state),
    .lsu_state(lsu_state), .next_pc(next_pc), .current_pc(pc_b),
    .active_mask(mask_b), .core_state(cs_b), .stack_ptr(sp_b),
    .done(done_b), .error(err_b));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH (fetcher ready, LSUs idle) through UPDATE.
  task automatic run_instr(input logic [31:0] npc, input logic r);
    int k;
    next_pc = npc;
    ret = r;
    k = 0;
    while (cs_a !== 3'd6 && k < 40) begin
      step(1);
      k++;
    end
    chk("reach_update", cs_a, 3'd6);
    step(1);
  endtask

  task automatic restart(input logic [2:0] tc);
    reset = 1'b1; start = 1'b0; ret = 1'b0; fma = 1'b0;
    step(1);
    reset = 1'b0; thread_count = tc; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_state", cs_a, 3'd0);
    chk("rst_pc", pc_a, 8'd0);
    chk("rst_mask", mask_a, 4'h0);
    chk("rst_sp", sp_a, 3'd0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_err", err_a, 2'd0);

    // Straight-line with FMA latency 3
    reset = 1'b0; thread_count = 3'd4; next_pc = {4{8'd1}}; fma = 1'b1; start = 1'b1;
    step(1);
    chk("launch_state", cs_a, 3'd1);
    chk("launch_mask", mask_a, 4'hF);
    start = 1'b0;
    step(1); chk("fetch_stall", cs_a, 3'd1);
    fetcher_state = 3'b010;
    step(1); chk("decode", cs_a, 3'd2);
    step(1); chk("request", cs_a, 3'd3);
    step(1); chk("wait", cs_a, 3'd4);
    step(1); chk("exec_c1", cs_a, 3'd5);
    step(1); chk("exec_c2", cs_a, 3'd5);
    step(1); chk("exec_c3", cs_a, 3'd5);
    step(1); chk("update", cs_a, 3'd6);
    chk("pc_before_upd", pc_a, 8'd0);
    step(1); chk("pc_1", pc_a, 8'd1); chk("fetch_again", cs_a, 3'd1);
    fma = 1'b0; next_pc = {4{8'd2}};
    step(5); chk("upd_6cyc", cs_a, 3'd6);
    step(1); chk("pc_2", pc_a, 8'd2); chk("fetch_6cyc", cs_a, 3'd1);
    ret = 1'b1;
    step(6);
    chk("ret_state", cs_a, 3'd7);
    chk("ret_done", done_a, 1'b1);
    chk("ret_err", err_a, 2'd0);
    chk("ret_pc_hold", pc_a, 8'd2);
    start = 1'b1;
    step(3);
    chk("done_hold", cs_a, 3'd7);
    chk("done_sticky", done_a, 1'b1);

    // Partial block with LSU stalls
    lsu_state[3] = 2'b10;
    next_pc = {4{8'd1}};
    restart(3'd3);
    chk("part_mask", mask_a, 4'h7);
    step(3); chk("part_wait", cs_a, 3'd4);
    step(1); chk("inactive_lsu_ignored", cs_a, 3'd5);
    step(2); chk("part_pc1", pc_a, 8'd1);
    next_pc = {4{8'd2}};
    step(3); chk("part_wait2", cs_a, 3'd4);
    lsu_state[1] = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("wait_hold%0d", i), cs_a, 3'd4);
    end
    lsu_state[1] = 2'b00;
    step(1); chk("wait_exit", cs_a, 3'd5);
    step(2); chk("part_pc2", pc_a, 8'd2); chk("part_mask_keep", mask_a, 4'h7);
    lsu_state = '0;

    // Divergence then reconvergence
    restart(3'd4);
    run_instr({4{8'd4}}, 1'b0);
    chk("dv_pc4", pc_a, 8'd4);
    run_instr({8'd9, 8'd9, 8'd5, 8'd5}, 1'b0);
    chk("dv_mask", mask_a, 4'h3);
    chk("dv_pc", pc_a, 8'd5);
    chk("dv_sp", sp_a, 3'd1);
    chk("dv_state", cs_a, 3'd1);
    run_instr({8'd7, 8'd7, 8'd8, 8'd8}, 1'b0);
    chk("dv_pc8", pc_a, 8'd8);
    chk("dv_mask8", mask_a, 4'h3);
    chk("dv_sp8", sp_a, 3'd1);
    run_instr({4{8'd9}}, 1'b0);
    chk("rc_mask", mask_a, 4'hF);
    chk("rc_pc", pc_a, 8'd9);
    chk("rc_sp", sp_a, 3'd0);

    // RET pops the pending group
    restart(3'd4);
    run_instr({4{8'd4}}, 1'b0);
    run_instr({8'd9, 8'd9, 8'd5, 8'd5}, 1'b0);
    run_instr({8'd9, 8'd9, 8'd5, 8'd5}, 1'b1);
    chk("retpop_mask", mask_a, 4'hC);
    chk("retpop_pc", pc_a, 8'd9);
    chk("retpop_state", cs_a, 3'd1);
    chk("retpop_done", done_a, 1'b0);
    chk("retpop_sp", sp_a, 3'd0);
    run_instr({4{8'd9}}, 1'b1);
    chk("ret2_done", done_a, 1'b1);
    chk("ret2_state", cs_a, 3'd7);

    // Stack overflow on the depth-1 instance
    restart(3'd4);
    run_instr({4{8'd4}}, 1'b0);
    run_instr({8'd9, 8'd9, 8'd5, 8'd5}, 1'b0);
    chk("ovf_sp_b", sp_b, 1'b1);
    run_instr({8'd7, 8'd7, 8'd7, 8'd6}, 1'b0);
    chk("ovf_err_b", err_b, 2'b01);
    chk("ovf_done_b", done_b, 1'b1);
    chk("ovf_state_b", cs_b, 3'd7);
    chk("ovf_mask_b", mask_b, 4'h3);
    chk("ovf_pc_b", pc_b, 8'd5);
    chk("nest_sp_a", sp_a, 3'd2);
    chk("nest_mask_a", mask_a, 4'h1);
    chk("nest_pc_a", pc_a, 8'd6);
    chk("nest_err_a", err_a, 2'b00);

    // Three distinct targets
    restart(3'd4);
    run_instr({4{8'd4}}, 1'b0);
    run_instr({8'd12, 8'd12, 8'd9, 8'd5}, 1'b0);
    chk("multi_err", err_a, 2'b10);
    chk("multi_done", done_a, 1'b1);
    chk("multi_state", cs_a, 3'd7);
    chk("multi_pc", pc_a, 8'd4);
    chk("multi_mask", mask_a, 4'hF);
    chk("multi_sp", sp_a, 3'd0);

    // Reset during EXECUTE with a pending stack entry
    restart(3'd4);
    run_instr({4{8'd4}}, 1'b0);
    run_instr({8'd9, 8'd9, 8'd5, 8'd5}, 1'b0);
    next_pc = {4{8'd6}};
    step(4);
    chk("mid_exec", cs_a, 3'd5);
    chk("mid_sp", sp_a, 3'd1);
    reset = 1'b1;
    step(1);
    chk("mid_rst_state", cs_a, 3'd0);
    chk("mid_rst_pc", pc_a, 8'd0);
    chk("mid_rst_mask", mask_a, 4'h0);
    chk("mid_rst_sp", sp_a, 3'd0);
    chk("mid_rst_done", done_a, 1'b0);
    chk("mid_rst_err", err_a, 2'd0);

    // Zero threads
    reset = 1'b0; thread_count = 3'd0; start = 1'b1;
    step(1);
    start = 1'b0;
    chk("zero_state", cs_a, 3'd7);
    chk("zero_done", done_a, 1'b1);
    chk("zero_mask", mask_a, 4'h0);
    chk("zero_err", err_a, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
